// File: rtl/echo_collect.sv
// echo_collect: opens a WIN_CYC-cycle measurement window on each laser-fire
// pulse, captures the first three TDC hits ({coarse, fine} timestamp plus
// 5-bit intensity) and offers them as one frame over a valid/ready handshake.
// The intensity sorter downstream takes int_a/int_b/int_c as its data inputs.
module echo_collect #(
  parameter int CW      = 10,  // coarse counter width
  parameter int FW      = 6,   // fine-time width from the TDC interpolator
  parameter int WIN_CYC = 800  // window length in clk cycles, 2 .. 2**CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit_valid,
  input  logic [FW-1:0]      hit_fine,
  input  logic [4:0]         hit_int,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         int_a,
  output logic [4:0]         int_b,
  output logic [4:0]         int_c,
  output logic [CW+FW-1:0]   time_a,
  output logic [CW+FW-1:0]   time_b,
  output logic [CW+FW-1:0]   time_c,
  output logic [1:0]         hit_cnt,
  output logic               ovf,
  output logic               busy,
  output logic               start_drop
);

  // Counter value of the final window cycle; the counter stops here and
  // never wraps, so WIN_CYC = 2**CW still fits in CW bits.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Window FSM: control, capture slots and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the capture slots are plain flops, not a RAM, so they are
      // cleared by reset like any other state; unfilled slots must read 0.
      state      <= IDLE;
      cnt        <= '0;
      hit_cnt    <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      start_drop <= 1'b0;
      int_a      <= '0;
      int_b      <= '0;
      int_c      <= '0;
      time_a     <= '0;
      time_b     <= '0;
      time_c     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of cnt/hit_cnt regardless of order.
      start_drop <= 1'b0;
      case (state)
        IDLE: begin
          // Hits are ignored here, including one coincident with start.
          if (start) begin
            state   <= ARMED;
            busy    <= 1'b1;
            cnt     <= '0;
            hit_cnt <= '0;
            ovf     <= 1'b0;
            int_a   <= '0;
            int_b   <= '0;
            int_c   <= '0;
            time_a  <= '0;
            time_b  <= '0;
            time_c  <= '0;
          end
        end

        ARMED: begin
          if (start) start_drop <= 1'b1;
          if (hit_valid) begin
            case (hit_cnt)
              2'd0: begin
                int_a  <= hit_int;
                time_a <= {cnt, hit_fine};
              end
              2'd1: begin
                int_b  <= hit_int;
                time_b <= {cnt, hit_fine};
              end
              2'd2: begin
                int_c  <= hit_int;
                time_c <= {cnt, hit_fine};
              end
              default: ovf <= 1'b1;  // fourth and later hits: slots frozen
            endcase
            if (hit_cnt != 2'd3) hit_cnt <= hit_cnt + 2'd1;
          end
          // A hit in the last cycle is still captured above.
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // Frame outputs are simply not written here, so they hold until
          // the handshake and then on through IDLE until the next start.
          if (start) start_drop <= 1'b1;
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_collect.sv
// Testbench for echo_collect: directed scenarios plus randomized windows,
// checked against a queue-based model of "which hits landed in the window".
module tb_echo_collect;

  localparam int CW  = 10;
  localparam int FW  = 6;
  localparam int WIN = 8;
  localparam int TW  = CW + FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hit_valid;
  logic [FW-1:0] hit_fine;
  logic [4:0]    hit_int;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    int_a, int_b, int_c;
  logic [TW-1:0] time_a, time_b, time_c;
  logic [1:0]    hit_cnt;
  logic          ovf;
  logic          busy;
  logic          start_drop;

  echo_collect #(.CW(CW), .FW(FW), .WIN_CYC(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit_valid  (hit_valid),
    .hit_fine   (hit_fine),
    .hit_int    (hit_int),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_a      (int_a),
    .int_b      (int_b),
    .int_c      (int_c),
    .time_a     (time_a),
    .time_b     (time_b),
    .time_c     (time_c),
    .hit_cnt    (hit_cnt),
    .ovf        (ovf),
    .busy       (busy),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: every hit that falls inside the window, in arrival order.
  typedef struct {
    logic [TW-1:0] t;
    logic [4:0]    i;
  } hit_t;
  hit_t q[$];

  // Per-window hit pattern, indexed by the window cycle (counter value).
  bit            hv[WIN];
  logic [FW-1:0] hf[WIN];
  logic [4:0]    hi[WIN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] stamp(input int c, input logic [FW-1:0] f);
    return TW'(c * (2 ** FW) + int'(f));
  endfunction

  function automatic int n_capt();
    return (q.size() > 3) ? 3 : q.size();
  endfunction

  function automatic logic [4:0] exp_int(input int k);
    return (k < q.size()) ? q[k].i : 5'd0;
  endfunction

  function automatic logic [TW-1:0] exp_time(input int k);
    return (k < q.size()) ? q[k].t : '0;
  endfunction

  task automatic check_frame(input string tag);
    chk({tag, ".int_a"},  int_a,   exp_int(0));
    chk({tag, ".int_b"},  int_b,   exp_int(1));
    chk({tag, ".int_c"},  int_c,   exp_int(2));
    chk({tag, ".time_a"}, time_a,  exp_time(0));
    chk({tag, ".time_b"}, time_b,  exp_time(1));
    chk({tag, ".time_c"}, time_c,  exp_time(2));
    chk({tag, ".hit_cnt"}, hit_cnt, n_capt());
    chk({tag, ".ovf"},    ovf,     q.size() > 3);
  endtask

  task automatic clear_hits();
    for (int c = 0; c < WIN; c++) begin
      hv[c] = 1'b0;
      hf[c] = '0;
      hi[c] = '0;
    end
  endtask

  task automatic set_hit(input int c, input logic [FW-1:0] f, input logic [4:0] i);
    hv[c] = 1'b1;
    hf[c] = f;
    hi[c] = i;
  endtask

  // One full window: start, WIN armed cycles, DONE held for ready_lat cycles,
  // then the handshake. drop_at: window cycle with an extra start (-1 none).
  task automatic do_frame(input string tag, input int ready_lat, input int drop_at,
                          input bit drop_in_done, input bit hit_at_start);
    hit_t h;
    q.delete();
    start     = 1'b1;
    hit_valid = hit_at_start;
    hit_fine  = FW'($urandom);
    hit_int   = 5'($urandom);
    out_ready = 1'($urandom);
    @(posedge clk); #1;
    chk({tag, ".open.busy"},    busy,      1);
    chk({tag, ".open.valid"},   out_valid, 0);
    chk({tag, ".open.hit_cnt"}, hit_cnt,   0);
    chk({tag, ".open.int_a"},   int_a,     0);
    chk({tag, ".open.time_a"},  time_a,    0);
    for (int c = 0; c < WIN; c++) begin
      start     = (c == drop_at);
      hit_valid = hv[c];
      hit_fine  = hf[c];
      hit_int   = hi[c];
      out_ready = 1'($urandom);
      if (hv[c]) begin
        h.t = stamp(c, hf[c]);
        h.i = hi[c];
        q.push_back(h);
      end
      @(posedge clk); #1;
      chk({tag, ".win.valid"},   out_valid,  c == WIN - 1);
      chk({tag, ".win.drop"},    start_drop, c == drop_at);
      chk({tag, ".win.hit_cnt"}, hit_cnt,    n_capt());
    end
    start     = 1'b0;
    hit_valid = 1'b0;
    check_frame({tag, ".done"});
    for (int k = 0; k <= ready_lat; k++) begin
      out_ready = (k == ready_lat);
      start     = drop_in_done && (k == 0);
      hit_valid = 1'($urandom);
      hit_fine  = FW'($urandom);
      hit_int   = 5'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hs.valid"}, out_valid,  k < ready_lat);
      chk({tag, ".hs.busy"},  busy,       k < ready_lat);
      chk({tag, ".hs.drop"},  start_drop, drop_in_done && (k == 0));
      check_frame({tag, ".hs"});
    end
    start     = 1'b0;
    out_ready = 1'b0;
    hit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    hit_valid = 1'b0;
    hit_fine  = '0;
    hit_int   = '0;
    out_ready = 1'b0;
    clear_hits();
    q.delete();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.busy",  busy,      0);
    chk("rst.drop",  start_drop, 0);
    check_frame("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Three hits at counters 1, 4, 7, ready immediately.
    clear_hits();
    set_hit(1, 6'd5, 5'd20);
    set_hit(4, 6'd0, 5'd7);
    set_hit(7, 6'd63, 5'd31);
    do_frame("tp1", 0, -1, 1'b0, 1'b0);
    chk("tp1.abs.int_a",  int_a,  20);
    chk("tp1.abs.int_b",  int_b,  7);
    chk("tp1.abs.int_c",  int_c,  31);
    chk("tp1.abs.time_a", time_a, 16'h0045);
    chk("tp1.abs.time_c", time_c, 16'h01FF);

    // Five hits: only the first three captured, overflow flagged.
    clear_hits();
    set_hit(0, 6'd1, 5'd3);
    set_hit(2, 6'd2, 5'd9);
    set_hit(3, 6'd3, 5'd17);
    set_hit(5, 6'd4, 5'd25);
    set_hit(6, 6'd5, 5'd30);
    do_frame("ovf", 0, -1, 1'b0, 1'b0);
    chk("ovf.abs.ovf", ovf, 1);

    // No hits, downstream stalls for 5 cycles.
    clear_hits();
    do_frame("stall", 5, -1, 1'b0, 1'b0);

    // Extra starts at counter 3 and in DONE are dropped.
    clear_hits();
    set_hit(2, 6'd10, 5'd11);
    set_hit(6, 6'd20, 5'd12);
    do_frame("drop", 2, 3, 1'b1, 1'b0);

    // Reset mid-window after two hits.
    clear_hits();
    set_hit(1, 6'd7, 5'd8);
    set_hit(3, 6'd9, 5'd10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      hit_valid = hv[c];
      hit_fine  = hf[c];
      hit_int   = hi[c];
      @(posedge clk); #1;
    end
    hit_valid = 1'b0;
    chk("mrst.pre.hit_cnt", hit_cnt, 2);
    rst = 1'b1;
    #1;
    q.delete();
    chk("mrst.valid", out_valid, 0);
    chk("mrst.busy",  busy,      0);
    check_frame("mrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < WIN + 3; c++) begin
      hit_valid = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("mrst.after.valid",   out_valid, 0);
      chk("mrst.after.hit_cnt", hit_cnt,   0);
    end
    hit_valid = 1'b0;
    out_ready = 1'b0;
    clear_hits();
    set_hit(0, 6'd33, 5'd1);
    do_frame("mrst.clean", 1, -1, 1'b0, 1'b0);

    // Hit coincident with start is ignored; last-cycle hit is captured.
    clear_hits();
    set_hit(WIN - 1, 6'd42, 5'd19);
    do_frame("last", 0, -1, 1'b0, 1'b1);
    chk("last.abs.time_a", time_a, (WIN - 1) * 64 + 42);
    chk("last.abs.hit_cnt", hit_cnt, 1);

    // Randomized windows with idle gaps, stalls and stray starts.
    for (int n = 0; n < 25; n++) begin
      int thr;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        hit_valid = 1'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        chk("gap.valid",   out_valid, 0);
        chk("gap.busy",    busy,      0);
        chk("gap.hit_cnt", hit_cnt,   n_capt());
      end
      hit_valid = 1'b0;
      thr = $urandom_range(0, 100);
      for (int c = 0; c < WIN; c++) begin
        hv[c] = ($urandom_range(0, 99) < thr);
        hf[c] = FW'($urandom);
        hi[c] = 5'($urandom);
      end
      do_frame("rnd", $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIN - 1)) : -1,
               1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
